ascii_matrix_load_ctrl: RTL and testbench

Sequencer placed after the ASCII number separator (`ascii_num_sep_top`). Once the separator reports done, this block:
- reads the parsed integer list from the separator's RAM through its read port;
- interprets the first two values as matrix rows and columns;
- checks the list against those dimensions;
- streams the elements, in row-major order, into matrix storage over a valid/ready write port.

It also reports load status to the top-level calculator FSM and requests a separator clear when it finishes.

---
 rtl/ascii_matrix_load_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ascii_matrix_load_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_matrix_load_ctrl.sv
// Sequencer that pulls the separator's parsed integer list, validates the matrix
// dimensions it encodes and streams the elements row-major over a valid/ready port.
module ascii_matrix_load_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_DIM    = 5,
  parameter int DIM_WIDTH  = 3,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sep_done,
  input  logic                  sep_invalid,
  input  logic [ADDR_WIDTH-1:0] sep_num_count,
  output logic [ADDR_WIDTH-1:0] sep_rd_addr,
  input  logic [DATA_WIDTH-1:0] sep_rd_data,
  output logic                  sep_clear,
  output logic                  mat_wr_valid,
  input  logic                  mat_wr_ready,
  output logic [DIM_WIDTH-1:0]  mat_wr_row,
  output logic [DIM_WIDTH-1:0]  mat_wr_col,
  output logic [DATA_WIDTH-1:0] mat_wr_data,
  output logic [DIM_WIDTH-1:0]  mat_rows,
  output logic [DIM_WIDTH-1:0]  mat_cols,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD_ROWS, S_RD_COLS, S_VALIDATE,
    S_RD_ELEM, S_WR_ELEM, S_DONE, S_ERROR, S_WAIT_REL
  } state_e;

  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = 8;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rows_raw_q, rows_raw_d, cols_raw_q, cols_raw_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [DIM_WIDTH-1:0]  mat_rows_q, mat_rows_d, mat_cols_q, mat_cols_d;
  logic [1:0]            err_q, err_d;

  logic          dims_ok, count_ok, last_elem;
  logic [PW-1:0] prod, need_cnt;

  // Dimensions are signed: a negative count must fail the range check, not wrap.
  assign dims_ok = ($signed(rows_raw_q) >= 1) && ($signed(rows_raw_q) <= MAX_DIM) &&
                   ($signed(cols_raw_q) >= 1) && ($signed(cols_raw_q) <= MAX_DIM);
  assign prod      = rows_raw_q[PW-1:0] * cols_raw_q[PW-1:0];
  assign need_cnt  = prod + PW'(2);
  assign count_ok  = (need_cnt == {1'b0, sep_num_count});
  assign last_elem = (row_q == mat_rows_q - DIM_WIDTH'(1)) &&
                     (col_q == mat_cols_q - DIM_WIDTH'(1));

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    addr_d     = addr_q;
    rows_raw_d = rows_raw_q;
    cols_raw_d = cols_raw_q;
    data_d     = data_q;
    row_d      = row_q;
    col_d      = col_q;
    mat_rows_d = mat_rows_q;
    mat_cols_d = mat_cols_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (sep_done) begin
          err_d   = 2'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sep_invalid) begin
          err_d   = 2'd1;
          state_d = S_ERROR;
        end else if (sep_num_count < ADDR_WIDTH'(2)) begin
          err_d   = 2'd2;
          state_d = S_ERROR;
        end else begin
          addr_d  = '0;
          state_d = S_RD_ROWS;
        end
      end
      S_RD_ROWS: begin
        if (cnt_q == CW'(RD_LATENCY)) begin
          rows_raw_d = sep_rd_data;
          addr_d     = ADDR_WIDTH'(1);
          state_d    = S_RD_COLS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_COLS: begin
        if (cnt_q == CW'(RD_LATENCY)) begin
          cols_raw_d = sep_rd_data;
          state_d    = S_VALIDATE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VALIDATE: begin
        if (!dims_ok) begin
          err_d   = 2'd2;
          state_d = S_ERROR;
        end else if (!count_ok) begin
          err_d   = 2'd3;
          state_d = S_ERROR;
        end else begin
          mat_rows_d = rows_raw_q[DIM_WIDTH-1:0];
          mat_cols_d = cols_raw_q[DIM_WIDTH-1:0];
          row_d      = '0;
          col_d      = '0;
          addr_d     = ADDR_WIDTH'(2);
          state_d    = S_RD_ELEM;
        end
      end
      S_RD_ELEM: begin
        if (cnt_q == CW'(RD_LATENCY - 1)) begin
          data_d  = sep_rd_data;
          state_d = S_WR_ELEM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR_ELEM: begin
        if (mat_wr_ready) begin
          if (col_q == mat_cols_q - DIM_WIDTH'(1)) begin
            col_d = '0;
            row_d = row_q + DIM_WIDTH'(1);
          end else begin
            col_d = col_q + DIM_WIDTH'(1);
          end
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = last_elem ? S_DONE : S_RD_ELEM;
        end
      end
      S_DONE:     state_d = S_WAIT_REL;
      S_ERROR:    state_d = S_WAIT_REL;
      S_WAIT_REL: if (!sep_done) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rows_raw_q <= '0;
      cols_raw_q <= '0;
      data_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      mat_rows_q <= '0;
      mat_cols_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rows_raw_q <= rows_raw_d;
      cols_raw_q <= cols_raw_d;
      data_q     <= data_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mat_rows_q <= mat_rows_d;
      mat_cols_q <= mat_cols_d;
      err_q      <= err_d;
    end
  end

  // Handshake and pulse outputs decode the state register, so reset clears them at once.
  assign mat_wr_valid = (state_q == S_WR_ELEM);
  assign load_done    = (state_q == S_DONE);
  assign load_error   = (state_q == S_ERROR);
  assign sep_clear    = load_done || load_error;
  assign busy         = (state_q != S_IDLE);
  assign sep_rd_addr  = addr_q;
  assign mat_wr_row   = row_q;
  assign mat_wr_col   = col_q;
  assign mat_wr_data  = data_q;
  assign mat_rows     = mat_rows_q;
  assign mat_cols     = mat_cols_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_ascii_matrix_load_ctrl.sv
// Scoreboard bench for ascii_matrix_load_ctrl: directed lists go into a model of the
// separator RAM, expected writes/outcomes are queued and a negedge monitor compares.
module tb_ascii_matrix_load_ctrl;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int DMW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sep_done = 1'b0, sep_invalid = 1'b0;
  logic [AW-1:0] sep_num_count = '0;
  logic [AW-1:0] sep_rd_addr;
  logic [DW-1:0] sep_rd_data;
  logic          sep_clear, mat_wr_valid;
  logic          mat_wr_ready = 1'b1;
  logic [DMW-1:0] mat_wr_row, mat_wr_col, mat_rows, mat_cols;
  logic [DW-1:0] mat_wr_data;
  logic          busy, load_done, load_error;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  ascii_matrix_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sep_done(sep_done), .sep_invalid(sep_invalid),
    .sep_num_count(sep_num_count), .sep_rd_addr(sep_rd_addr), .sep_rd_data(sep_rd_data),
    .sep_clear(sep_clear), .mat_wr_valid(mat_wr_valid), .mat_wr_ready(mat_wr_ready),
    .mat_wr_row(mat_wr_row), .mat_wr_col(mat_wr_col), .mat_wr_data(mat_wr_data),
    .mat_rows(mat_rows), .mat_cols(mat_cols), .busy(busy), .load_done(load_done),
    .load_error(load_error), .err_code(err_code)
  );

  // Separator RAM model: data for an address is sampleable two edges after it changes.
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] rd_pipe = '0;
  always @(posedge clk) rd_pipe <= mem[sep_rd_addr[5:0]];
  assign sep_rd_data = rd_pipe;

  typedef struct packed {
    logic [DMW-1:0] row;
    logic [DMW-1:0] col;
    logic [DW-1:0]  data;
  } wr_t;
  typedef struct packed {
    logic           err;
    logic [1:0]     code;
    logic [DMW-1:0] rows;
    logic [DMW-1:0] cols;
  } out_t;

  wr_t  exp_wr[$];
  out_t exp_out[$];
  int   n_tests = 0, n_fail = 0;
  int   acc_cnt = 0, clr_cnt = 0, ev_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h expected no such event", name, act);
  endtask

  function automatic logic [63:0] all_outputs();
    return {2'b0, sep_rd_addr, sep_clear, mat_wr_valid, mat_wr_row, mat_wr_col,
            mat_wr_data, mat_rows, mat_cols, busy, load_done, load_error, err_code};
  endfunction

  // Monitor: samples on the falling edge, between the stimulus updates and the active edge.
  logic        stall_prev = 1'b0;
  logic [63:0] stall_snap = '0;
  wr_t         w;
  out_t        o;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {25'd0, mat_wr_valid, mat_wr_row, mat_wr_col, mat_wr_data}, stall_snap);
      stall_prev = mat_wr_valid && !mat_wr_ready;
      stall_snap = {25'd0, 1'b1, mat_wr_row, mat_wr_col, mat_wr_data};
      if (mat_wr_valid && mat_wr_ready) begin
        acc_cnt++;
        if (exp_wr.size() == 0) begin
          fail("unexpected_write", {26'd0, mat_wr_row, mat_wr_col, mat_wr_data});
        end else begin
          w = exp_wr.pop_front();
          check("write", {26'd0, mat_wr_row, mat_wr_col, mat_wr_data}, {26'd0, w});
        end
      end
      if (load_done || load_error) begin
        ev_cnt++;
        if (exp_out.size() == 0) begin
          fail("unexpected_outcome", {55'd0, load_error, err_code, mat_rows, mat_cols});
        end else begin
          o = exp_out.pop_front();
          check("outcome", {55'd0, load_error, err_code, mat_rows, mat_cols}, {55'd0, o});
          check("writes_left_at_end", 64'(exp_wr.size()), 64'd0);
        end
      end
      if (sep_clear) clr_cnt++;
      if (sep_clear != (load_done || load_error))
        fail("clear_pulse_align", {61'd0, sep_clear, load_done, load_error});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input int v);
    mem[idx] = v;
  endtask

  task automatic push_wr(input int r, input int c, input int d);
    wr_t x;
    x.row = DMW'(r);
    x.col = DMW'(c);
    x.data = d;
    exp_wr.push_back(x);
  endtask

  task automatic push_out(input bit err, input int code, input int r, input int c);
    out_t x;
    x.err = err;
    x.code = 2'(code);
    x.rows = DMW'(r);
    x.cols = DMW'(c);
    exp_out.push_back(x);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin tick(1); k++; end
    if (busy) fail("timeout_idle", {63'd0, busy});
  endtask

  // Raises sep_done and waits for the outcome pulse; optionally stalls the first write.
  task automatic run_load(input int count, input bit inv, input int stall, input bit release_done);
    int k;
    sep_num_count = AW'(count);
    sep_invalid = inv;
    if (stall > 0) mat_wr_ready = 1'b0;
    sep_done = 1'b1;
    if (stall > 0) begin
      k = 0;
      while (!mat_wr_valid && k < 200) begin tick(1); k++; end
      if (!mat_wr_valid) fail("timeout_first_valid", {63'd0, mat_wr_valid});
      tick(stall);
      mat_wr_ready = 1'b1;
    end
    k = 0;
    while (!(load_done || load_error) && k < 500) begin tick(1); k++; end
    if (!(load_done || load_error)) fail("timeout_load", {62'd0, load_done, load_error});
    tick(1);
    if (release_done) begin
      sep_done = 1'b0;
      sep_invalid = 1'b0;
      wait_idle();
      tick(2);
    end
  endtask

  initial begin
    int ev_before, acc_before, k;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    tick(3);
    check("reset_outputs", all_outputs(), 64'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_after_reset", all_outputs(), 64'd0);

    // 2x3 load with ready high
    put(0, 2); put(1, 3); put(2, 1); put(3, 2); put(4, 3); put(5, 4); put(6, 5); put(7, 6);
    push_wr(0, 0, 1); push_wr(0, 1, 2); push_wr(0, 2, 3);
    push_wr(1, 0, 4); push_wr(1, 1, 5); push_wr(1, 2, 6);
    push_out(0, 0, 2, 3);
    run_load(8, 0, 0, 1);

    // count mismatch: 2x2 needs 6 entries, only 5 present
    put(0, 2); put(1, 2); put(2, 1); put(3, 2); put(4, 3);
    push_out(1, 3, 2, 3);
    run_load(5, 0, 0, 1);

    // parse invalid flagged by the separator
    push_out(1, 1, 2, 3);
    run_load(8, 1, 0, 1);

    // bad dimensions: zero, too large, negative
    put(0, 0); put(1, 3);
    push_out(1, 2, 2, 3);
    run_load(2, 0, 0, 1);
    put(0, 6); put(1, 1);
    push_out(1, 2, 2, 3);
    run_load(8, 0, 0, 1);
    put(0, -1); put(1, 2);
    push_out(1, 2, 2, 3);
    run_load(4, 0, 0, 1);

    // 1x2 with a three-cycle ready stall on the first element
    put(0, 1); put(1, 2); put(2, -7); put(3, 32'h7fffffff);
    push_wr(0, 0, -7); push_wr(0, 1, 32'h7fffffff);
    push_out(0, 0, 1, 2);
    run_load(4, 0, 3, 1);

    // sep_done held after load_done must not restart a load
    put(0, 1); put(1, 1); put(2, 42);
    push_wr(0, 0, 42);
    push_out(0, 0, 1, 1);
    run_load(3, 0, 0, 0);
    ev_before = ev_cnt;
    tick(20);
    check("held_busy", {63'd0, busy}, 64'd1);
    check("held_no_reload", 64'(ev_cnt), 64'(ev_before));
    sep_done = 1'b0;
    wait_idle();
    check("released_idle", {63'd0, busy}, 64'd0);
    tick(2);
    push_wr(0, 0, 42);
    push_out(0, 0, 1, 1);
    run_load(3, 0, 0, 1);
    check("second_load_after_release", 64'(ev_cnt), 64'(ev_before + 1));

    // 3x3 load aborted by reset while the second element is presented
    put(0, 3); put(1, 3);
    for (int i = 0; i < 9; i++) put(2 + i, 10 + i);
    push_wr(0, 0, 10);
    acc_before = acc_cnt;
    sep_num_count = AW'(11);
    sep_done = 1'b1;
    k = 0;
    while (!(acc_cnt == acc_before + 1 && mat_wr_valid) && k < 200) begin tick(1); k++; end
    if (!(acc_cnt == acc_before + 1 && mat_wr_valid))
      fail("timeout_second_elem", 64'(acc_cnt));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 64'd0);
    sep_done = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_abort_idle", all_outputs(), 64'd0);
    check("abort_write_count", 64'(acc_cnt), 64'(acc_before + 1));

    tick(3);
    check("queues_empty", 64'(exp_wr.size() + exp_out.size()), 64'd0);
    check("clear_count", 64'(clr_cnt), 64'(ev_cnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
